uart_transmitter_fpga_status: RTL and testbench
===============================================

UART_TRANSMITTER_FPGA_STATUS -- requirements
Module: uart_transmitter_fpga_status

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
REQ-002 Parameter FIFO_DEPTH, default 4, byte entries in the transmit FIFO; power of two, >= 2.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 data_in  input  8  byte to transmit (status/readback byte to host).
REQ-006 valid  input  1  data_in valid; byte accepted on a rising edge where valid && ready.
REQ-007 ready  output  1  FIFO can accept a byte this cycle.
REQ-008 tx  output  1  serial line, 8N1, idle high, LSB first.
REQ-009 busy  output  1  transmitter active or FIFO non-empty.

Function
REQ-010 The FIFO SHALL be circular with write/read pointers of log2(FIFO_DEPTH) bits plus a count of log2(FIFO_DEPTH)+1 bits; pointers wrap from FIFO_DEPTH-1 to 0.
REQ-011 ready SHALL equal (count != FIFO_DEPTH), combinational from registered count.
REQ-012 valid with ready low SHALL be ignored; no write, no state change, data_in not held.
REQ-013 Simultaneous push and pop in one cycle SHALL leave count unchanged and store/read both bytes correctly.
REQ-014 FSM states: IDLE, START, DATA, STOP.
REQ-015 IDLE: tx=1; when count != 0, pop head byte into shift register, clear bit counter and baud counter, go START.
REQ-016 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-017 DATA: tx = shift[0]; every CLKS_PER_BIT cycles shift right and increment bit index; after 8th bit period go STOP.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles; then if count != 0 pop next byte and go directly to START (no idle gap), else go IDLE.
REQ-019 tx SHALL be a registered output (no glitches); frame length exactly 10*CLKS_PER_BIT cycles.
REQ-020 Latency: byte accepted at edge N into empty FIFO with FSM in IDLE -> tx falls at edge N+2 (edge N+1 pop, edge N+2 tx register updates).
REQ-021 Baud counter width SHALL be clog2(CLKS_PER_BIT) bits; counts 0..CLKS_PER_BIT-1 then wraps to 0 and advances bit.
REQ-022 busy SHALL be (state != IDLE) || (count != 0).
REQ-023 Bytes SHALL be transmitted in acceptance order, none dropped or duplicated while ready was honoured.

Reset
REQ-024 rst low SHALL immediately (asynchronously) force state=IDLE, tx=1, count=0, pointers=0, counters=0, shift register=0.
REQ-025 Outputs under reset: tx=1, ready=1, busy=0.
REQ-026 Reset mid-frame SHALL abort the frame (tx high at once) and discard all queued bytes; no partial frame resumes after release.
REQ-027 First acceptance allowed on first rising edge after rst deasserts.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Single byte 0xA5 -> tx falls 2 cycles after accept; bits 0,1,0,1,0,0,1,0,1,1 each 4 cycles (40 total); busy high throughout, low after stop.
REQ-029 Burst 0x00,0xFF,0x55,0x3C,0x81 with valid held -> ready low after 4th queued entry until first pop; 5 frames back-to-back, 200 cycles, no idle gap, correct order.
REQ-030 Full FIFO plus valid with data 0x77 while ready=0 -> 0x77 never transmitted.
REQ-031 Pop-and-push same cycle at count=2 -> count stays 2; byte order preserved across pointer wrap.
REQ-032 rst low during DATA bit 3 of 0x96 with 2 bytes queued -> tx=1, ready=1, busy=0 immediately; after release, line stays high with no input.
REQ-033 Loopback: tx connected to the existing UART receiver at same baud -> every byte received equals byte sent, 256 consecutive values 0x00..0xFF.

Source files
------------

// File: rtl/uart_transmitter_fpga_status.sv
// 8N1 UART transmitter fed by a small circular byte FIFO; streams status bytes
// to the host back-to-back with no idle gap while the FIFO holds data.
module uart_transmitter_fpga_status #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;
    logic [7:0]       head;

    // Serializer
    state_e           state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             baud_last;
    logic             fifo_nonempty;

    assign ready         = (count_q != CNT_FULL);
    assign push          = valid && ready;
    assign head          = mem_q[rd_ptr_q];
    assign fifo_nonempty = (count_q != '0);
    assign baud_last     = (baud_q == BAUD_LAST);

    assign tx   = tx_q;
    assign busy = (state_q != ST_IDLE) || fifo_nonempty;

    // Pointer and occupancy update; a same-cycle push and pop leaves count alone
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never read before it is written, so it needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Frame sequencer; tx is registered from the current state, one cycle behind it
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        bit_d   = '0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_transmitter_fpga_status.sv
// Scoreboard bench: accepted bytes queue up as expected frames, an independent
// serial receiver decodes tx and checks byte value, framing and timing.
module tb_uart_transmitter_fpga_status;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic       tx;
    logic       busy;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         frames_done = 0;
    int         fall_log[$];
    logic [7:0] exp_q[$];

    logic [7:0] mon_rx;
    logic       mon_bit;
    bit         mon_shape_ok;
    bit         mon_aborted;
    int         mon_t0;
    logic [7:0] mon_exp;

    uart_transmitter_fpga_status #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .data_in(data_in),
        .valid  (valid),
        .ready  (ready),
        .tx     (tx),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge
    task automatic push_byte(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        data_in = b;
        valid   = 1'b1;
        while (ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            chk("push_timeout", 32'(ready), 32'd1);
            valid = 1'b0;
            acc   = cyc;
        end else begin
            exp_q.push_back(b);
            @(posedge clk);
            @(negedge clk);
            acc   = cyc;
            valid = 1'b0;
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("frame_count", 32'(frames_done), 32'(target));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Serial receiver: samples every cycle of a frame on the falling clock edge
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) begin
                mon_t0       = cyc;
                mon_shape_ok = 1'b1;
                mon_aborted  = 1'b0;
                mon_rx       = 8'h00;
                mon_bit      = 1'b0;
                for (int s = 0; s < int'(FRAME); s++) begin
                    if (s > 0) @(negedge clk);
                    if (rst !== 1'b1) begin
                        mon_aborted = 1'b1;
                        break;
                    end
                    if (s % CPB == 0) begin
                        mon_bit = tx;
                        if (s / CPB == 0 && mon_bit !== 1'b0) mon_shape_ok = 1'b0;
                        if (s / CPB == 9 && mon_bit !== 1'b1) mon_shape_ok = 1'b0;
                        if (s / CPB >= 1 && s / CPB <= 8) mon_rx[s / CPB - 1] = mon_bit;
                    end else if (tx !== mon_bit) begin
                        mon_shape_ok = 1'b0;
                    end
                end
                if (!mon_aborted) begin
                    fall_log.push_back(mon_t0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_frame: got byte 0x%02h expected no frame (cycle %0d)", mon_rx, cyc);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk("frame_byte", 32'(mon_rx), 32'(mon_exp));
                        chk("frame_shape", 32'(mon_shape_ok), 32'd1);
                    end
                    frames_done++;
                end
            end
        end
    end

    initial begin : stimulus
        int acc, acc0, base, base_log, dummy;
        bit ok;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single byte 0xA5: latency, busy window
        base = frames_done;
        push_byte(8'hA5, acc);
        ok = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            if (busy !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        chk("busy_during_frame", 32'(ok), 32'd1);
        wait_frames(base + 1, 200);
        chk("latency", 32'(fall_log[$] - acc), 32'd2);
        chk("busy_after_frame", 32'(busy), 32'd0);
        idle_cycles(5);

        // Burst of five with valid held, then a rejected 0x77 while full
        base     = frames_done;
        base_log = fall_log.size();
        push_byte(8'h00, acc0);
        push_byte(8'hFF, dummy);
        push_byte(8'h55, dummy);
        chk("ready_before_full", 32'(ready), 32'd1);
        push_byte(8'h3C, dummy);
        push_byte(8'h81, dummy);
        chk("ready_full", 32'(ready), 32'd0);
        data_in = 8'h77;
        valid   = 1'b1;
        ok      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (ready !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        valid = 1'b0;
        chk("ready_low_while_full", 32'(ok), 32'd1);
        wait_frames(base + 5, 400);
        if (fall_log.size() >= base_log + 5) begin
            chk("burst_latency", 32'(fall_log[base_log] - acc0), 32'd2);
            for (int i = 1; i < 5; i++)
                chk("burst_gap", 32'(fall_log[base_log + i] - fall_log[base_log + i - 1]), 32'(FRAME));
            chk("burst_span", 32'(fall_log[base_log + 4] + int'(FRAME) - fall_log[base_log]), 32'd200);
        end
        idle_cycles(60);
        chk("no_0x77", 32'(frames_done), 32'(base + 5));

        // Push coinciding with the end-of-frame pop at count=2
        base = frames_done;
        push_byte(8'($urandom), acc0);
        push_byte(8'($urandom), dummy);
        push_byte(8'($urandom), dummy);
        while (cyc < acc0 + 40) @(negedge clk);
        push_byte(8'($urandom), dummy);
        chk("pushpop_ready", 32'(ready), 32'd1);
        push_byte(8'($urandom), dummy);
        chk("pushpop_ready3", 32'(ready), 32'd1);
        push_byte(8'($urandom), dummy);
        chk("pushpop_full", 32'(ready), 32'd0);
        wait_frames(base + 6, 600);
        idle_cycles(5);

        // Reset during data bit 3 of 0x96 with two bytes queued
        base = frames_done;
        push_byte(8'h96, acc0);
        push_byte(8'($urandom), dummy);
        push_byte(8'($urandom), dummy);
        while (cyc < acc0 + 19) @(negedge clk);
        #2 rst = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        idle_cycles(3);
        rst = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        chk("idle_after_rst", 32'(ok), 32'd1);
        chk("no_resume", 32'(frames_done), 32'(base));

        // Random bytes with random gaps
        base = frames_done;
        for (int i = 0; i < 40; i++) begin
            push_byte(8'($urandom), dummy);
            idle_cycles(int'($urandom_range(0, 50)));
        end
        wait_frames(base + 40, 2000);

        // Loopback sweep 0x00..0xFF
        base = frames_done;
        for (int v = 0; v < 256; v++) push_byte(8'(v), dummy);
        wait_frames(base + 256, 300);
        idle_cycles(10);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
